// File: rtl/gpi_filter_pkg.sv
// Shared types and constants for the GPI input filter.
package gpi_filter_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam logic        GPI_IDLE_LEVEL   = 1'b1;
  localparam int unsigned GPI_SETTLE_EXTRA = 2;

endpackage

// File: rtl/gpi_filter_ch.sv
// One GPI channel: synchroniser, debounce filter, settle/arm logic and sticky edge flag.
module gpi_filter_ch
  import gpi_filter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pad_di,
  input  logic             en,
  input  logic [CNT_W-1:0] filt_len,
  input  logic [1:0]       edge_sel,
  input  logic             evt_clr,
  output logic             di,
  output logic             evt
);

  localparam int unsigned     SETTLE_CYC = SYNC_STAGES + GPI_SETTLE_EXTRA;
  localparam int unsigned     SET_W      = $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SETTLE_CYC);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic [SET_W-1:0]       settle;
  logic                   armed;

  logic       s;
  logic       mismatch;
  logic       flip;
  logic       hit;
  edge_mode_t mode;

  always_comb begin
    s        = sync[SYNC_STAGES-1];
    mode     = edge_mode_t'(edge_sel);
    mismatch = (s != di);
    // >= rather than == so a mid-count drop of the length cannot wrap the counter
    flip     = mismatch && (cnt >= filt_len);
    hit      = 1'b0;
    if (flip && armed) begin
      case (mode)
        EDGE_RISE: hit = s;
        EDGE_FALL: hit = ~s;
        EDGE_BOTH: hit = 1'b1;
        default:   hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= {SYNC_STAGES{GPI_IDLE_LEVEL}};
      di     <= GPI_IDLE_LEVEL;
      cnt    <= '0;
      settle <= '0;
      armed  <= 1'b0;
      evt    <= 1'b0;
    end else if (!en) begin
      sync   <= {SYNC_STAGES{GPI_IDLE_LEVEL}};
      di     <= GPI_IDLE_LEVEL;
      cnt    <= '0;
      settle <= '0;
      armed  <= 1'b0;
      evt    <= evt & ~evt_clr;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad_di};
      if (!mismatch) begin
        cnt <= '0;
      end else if (flip) begin
        di  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // Arming waits out the pad IE turn-on artefact before edges may raise events
      if (settle != SETTLE_MAX) begin
        settle <= settle + SET_W'(1);
      end else if (!mismatch && (cnt == '0)) begin
        armed <= 1'b1;
      end
      evt <= hit | (evt & ~evt_clr);
    end
  end

endmodule

// File: rtl/gpi_input_filter.sv
// GPI pad front end: registered pad input enable, per-channel filters, combined interrupt.
module gpi_input_filter
  import gpi_filter_pkg::*;
#(
  parameter int unsigned NCH         = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               CLK_I,
  input  logic               RSTN_I,
  input  logic [NCH-1:0]     PAD_DI_I,
  input  logic [NCH-1:0]     EN_I,
  input  logic [CNT_W-1:0]   FILT_LEN_I,
  input  logic [2*NCH-1:0]   EDGE_SEL_I,
  input  logic [NCH-1:0]     EVT_CLR_I,
  output logic [NCH-1:0]     IE_O,
  output logic [NCH-1:0]     DI_O,
  output logic [NCH-1:0]     EVT_O,
  output logic               IRQ_O
);

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      IE_O <= '0;
    end else begin
      IE_O <= EN_I;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    gpi_filter_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk      (CLK_I),
      .rst_n    (RSTN_I),
      .pad_di   (PAD_DI_I[c]),
      .en       (EN_I[c]),
      .filt_len (FILT_LEN_I),
      .edge_sel (EDGE_SEL_I[2*c+1:2*c]),
      .evt_clr  (EVT_CLR_I[c]),
      .di       (DI_O[c]),
      .evt      (EVT_O[c])
    );
  end

  assign IRQ_O = |EVT_O;

endmodule

// File: tb/tb_gpi_input_filter.sv
// Self-checking bench for gpi_input_filter: directed scenarios plus randomized run against a model.
module tb_gpi_input_filter;

  localparam int NCH    = 8;
  localparam int SYNC   = 2;
  localparam int SETTLE = SYNC + 2;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pad;
  logic [7:0]  en;
  logic [7:0]  filt;
  logic [15:0] esel;
  logic [7:0]  clr;
  logic [7:0]  ie;
  logic [7:0]  di;
  logic [7:0]  evt;
  logic        irq;

  int checks = 0;
  int errors = 0;

  gpi_input_filter #(.NCH(NCH), .SYNC_STAGES(SYNC), .CNT_W(8)) dut (
    .CLK_I      (clk),
    .RSTN_I     (rst_n),
    .PAD_DI_I   (pad),
    .EN_I       (en),
    .FILT_LEN_I (filt),
    .EDGE_SEL_I (esel),
    .EVT_CLR_I  (clr),
    .IE_O       (ie),
    .DI_O       (di),
    .EVT_O      (evt),
    .IRQ_O      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (random test) ----------------
  bit padq  [NCH][$];
  bit shist [NCH][$];
  bit m_lvl [NCH];
  bit m_arm [NCH];
  bit m_evt [NCH];
  int m_edges [NCH];
  logic [7:0] m_ie;

  task automatic model_reset;
    for (int c = 0; c < NCH; c++) begin
      padq[c].delete();
      repeat (SYNC) padq[c].push_back(1'b1);
      shist[c].delete();
      m_lvl[c] = 1'b1;
      m_arm[c] = 1'b0;
      m_evt[c] = 1'b0;
      m_edges[c] = 0;
    end
    m_ie = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step(input int L);
    bit s, prev_same, flip, set, arm_now;
    for (int c = 0; c < NCH; c++) begin
      if (!en[c]) begin
        padq[c].delete();
        repeat (SYNC) padq[c].push_back(1'b1);
        shist[c].delete();
        m_lvl[c] = 1'b1;
        m_arm[c] = 1'b0;
        m_edges[c] = 0;
        m_evt[c] = m_evt[c] & ~clr[c];
      end else begin
        s = padq[c][SYNC-1];
        prev_same = (shist[c].size() == 0) || (shist[c][0] == m_lvl[c]);
        // level flips when this sample and the L before it all disagree with it
        flip = (s != m_lvl[c]) && (shist[c].size() >= L);
        for (int k = 0; k < L; k++)
          if (flip && shist[c][k] == m_lvl[c]) flip = 1'b0;
        set = 1'b0;
        if (flip && m_arm[c]) set = s ? esel[2*c] : esel[2*c+1];
        arm_now = (m_edges[c] >= SETTLE) && (s == m_lvl[c]) && prev_same;
        if (flip) m_lvl[c] = s;
        if (arm_now) m_arm[c] = 1'b1;
        if (m_edges[c] < 1000) m_edges[c]++;
        m_evt[c] = set | (m_evt[c] & ~clr[c]);
        shist[c].push_front(s);
        if (shist[c].size() > 16) void'(shist[c].pop_back());
        padq[c].push_front(pad[c]);
        void'(padq[c].pop_back());
      end
    end
    m_ie = en;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0; en = '0; pad = '1; clr = '0; filt = '0; esel = '0;
    repeat (3) tick;
    checks++;
    if ({ie, di, evt, irq} !== {8'h00, 8'hFF, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_held ie=%h di=%h evt=%h irq=%b expected ie=00 di=ff evt=00 irq=0", ie, di, evt, irq);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      checks++;
      if ({ie, di, evt, irq} !== {8'h00, 8'hFF, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle cyc %0d ie=%h di=%h evt=%h irq=%b expected ie=00 di=ff evt=00 irq=0", i, ie, di, evt, irq);
      end
    end
  endtask

  task automatic test_enable_artefact;
    int n = 0;
    filt = 8'd0; esel[1:0] = 2'b11; pad[0] = 1'b0; en = 8'h01;
    while (ie[0] !== 1'b1 && n < 10) begin
      tick;
      n++;
    end
    checks++;
    if (ie[0] !== 1'b1) begin
      errors++;
      $display("FAIL enable_ie timeout ie=%h expected bit0=1", ie);
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL enable_ie_latency got %0d cycles expected 1", n);
    end
    pad[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      checks++;
      if (evt[0] !== 1'b0 || irq !== 1'b0) begin
        errors++;
        $display("FAIL enable_artefact_evt cyc %0d evt=%h irq=%b expected 0", i, evt, irq);
      end
    end
    checks++;
    if (di[0] !== 1'b1) begin
      errors++;
      $display("FAIL enable_artefact_di got %b expected 1", di[0]);
    end
  endtask

  task automatic test_debounce;
    filt = 8'd4; esel[1:0] = 2'b10;
    tick;
    pad[0] = 1'b0;
    repeat (4) tick;
    pad[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      checks++;
      if (di[0] !== 1'b1 || evt[0] !== 1'b0) begin
        errors++;
        $display("FAIL debounce_short cyc %0d di0=%b evt0=%b expected di0=1 evt0=0", i, di[0], evt[0]);
      end
    end
    pad[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick;
      if (i < 7) begin
        checks++;
        if (di[0] !== 1'b1 || irq !== 1'b0) begin
          errors++;
          $display("FAIL debounce_early cyc %0d di0=%b irq=%b expected di0=1 irq=0", i, di[0], irq);
        end
      end else begin
        checks++;
        if (di[0] !== 1'b0 || evt[0] !== 1'b1 || irq !== 1'b1) begin
          errors++;
          $display("FAIL debounce_flip di0=%b evt0=%b irq=%b expected 0 1 1", di[0], evt[0], irq);
        end
      end
      if (i == 5) pad[0] = 1'b1;
    end
    repeat (8) tick;
    checks++;
    if (di[0] !== 1'b1 || evt[0] !== 1'b1) begin
      errors++;
      $display("FAIL debounce_rise_nomode di0=%b evt0=%b expected 1 1", di[0], evt[0]);
    end
    clr = 8'h01;
    tick;
    clr = '0;
    checks++;
    if (evt !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL debounce_clear evt=%h irq=%b expected 00 0", evt, irq);
    end
  endtask

  task automatic test_edge_modes;
    filt = 8'd0; esel = 16'h00E4; en = 8'h0F;
    repeat (20) tick;
    clr = '1;
    tick;
    clr = '0;
    pad[3:0] = 4'h0;
    tick; tick;
    checks++;
    if (evt[3:0] !== 4'b0000) begin
      errors++;
      $display("FAIL modes_fall_early evt=%b expected 0000", evt[3:0]);
    end
    tick;
    checks++;
    if (evt[3:0] !== 4'b1100 || di[3:0] !== 4'h0) begin
      errors++;
      $display("FAIL modes_fall evt=%b di=%b expected evt=1100 di=0000", evt[3:0], di[3:0]);
    end
    repeat (5) tick;
    pad[3:0] = 4'hF;
    tick; tick;
    checks++;
    if (evt[3:0] !== 4'b1100) begin
      errors++;
      $display("FAIL modes_rise_early evt=%b expected 1100", evt[3:0]);
    end
    tick;
    checks++;
    if (evt[3:0] !== 4'b1110) begin
      errors++;
      $display("FAIL modes_rise evt=%b expected 1110", evt[3:0]);
    end
  endtask

  task automatic test_set_clear;
    clr = '1;
    tick;
    clr = '0;
    pad[1] = 1'b0;
    repeat (5) tick;
    checks++;
    if (di[1] !== 1'b0 || evt !== 8'h00) begin
      errors++;
      $display("FAIL setclr_fall di1=%b evt=%h expected di1=0 evt=00", di[1], evt);
    end
    pad[1] = 1'b1;
    tick; tick;
    clr[1] = 1'b1;
    tick;
    checks++;
    if (evt[1] !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL setclr_collision evt1=%b irq=%b expected 1 1", evt[1], irq);
    end
    tick;
    checks++;
    if (evt[1] !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL setclr_clear evt1=%b irq=%b expected 0 0", evt[1], irq);
    end
    clr = '0;
  endtask

  task automatic test_async_reset;
    filt = 8'd200;
    pad[0] = 1'b0;
    repeat (102) tick;
    checks++;
    if (di[0] !== 1'b1) begin
      errors++;
      $display("FAIL areset_precount di0=%b expected 1", di[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ie, di, evt, irq} !== {8'h00, 8'hFF, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL areset_immediate ie=%h di=%h evt=%h irq=%b expected ie=00 di=ff evt=00 irq=0", ie, di, evt, irq);
    end
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 203; i++) begin
      tick;
      if (i == 1) begin
        checks++;
        if (ie !== 8'h0F) begin
          errors++;
          $display("FAIL areset_ie got %h expected 0f", ie);
        end
      end
      if (i == 202) begin
        checks++;
        if (di !== 8'hFF) begin
          errors++;
          $display("FAIL areset_before_flip di=%h expected ff", di);
        end
      end
      if (i == 203) begin
        checks++;
        if (di !== 8'hFE) begin
          errors++;
          $display("FAIL areset_flip di=%h expected fe", di);
        end
      end
    end
    pad[0] = 1'b1;
  endtask

  task automatic test_random;
    int L;
    for (int seg = 0; seg < 2; seg++) begin
      L = $urandom_range(0, 3);
      rst_n = 1'b0; clr = '0; pad = '1; en = '0;
      filt = 8'(L);
      esel = 16'($urandom);
      tick;
      rst_n = 1'b1;
      model_reset();
      en = 8'($urandom);
      for (int cyc = 0; cyc < 1500; cyc++) begin
        if ($urandom_range(0, 99) == 0) en[$urandom_range(0, 7)] ^= 1'b1;
        for (int c = 0; c < NCH; c++) begin
          if ($urandom_range(0, 5) == 0) pad[c] = ~pad[c];
          clr[c] = ($urandom_range(0, 19) == 0);
        end
        if (cyc % 200 == 199) esel = 16'($urandom);
        model_step(L);
        tick;
        begin
          logic [7:0] exp_di, exp_evt;
          for (int c = 0; c < NCH; c++) begin
            exp_di[c]  = m_lvl[c];
            exp_evt[c] = m_evt[c];
          end
          checks++;
          if ({ie, di, evt, irq} !== {m_ie, exp_di, exp_evt, |exp_evt}) begin
            errors++;
            $display("FAIL random seg %0d cyc %0d L=%0d ie=%h di=%h evt=%h irq=%b expected ie=%h di=%h evt=%h irq=%b",
                     seg, cyc, L, ie, di, evt, irq, m_ie, exp_di, exp_evt, |exp_evt);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable_artefact();
    test_debounce();
    test_edge_modes();
    test_set_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
